// File: rtl/i2c_frame_counter.sv
// I2C frame position tracker: follows bit and byte position inside a frame
// using START/STOP flags from an upstream detector, clocked by rising scl.
//
// state | meaning
// IDLE  | no transfer in progress; scl edges ignored until a start
// ADDR  | address byte(s) in progress (1 or 2 bytes depending on ADDR10)
// DATA  | data bytes in progress; completed bytes counted up to MAX_BYTES
module i2c_frame_counter #(
  parameter int DATA_BITS = 8,
  parameter int MAX_BYTES = 16,
  parameter int ADDR10    = 0,
  localparam int BW = $clog2(DATA_BITS + 1),
  localparam int CW = $clog2(MAX_BYTES + 1)
) (
  input  logic          scl,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic [BW-1:0] bit_idx,
  output logic          ack_slot,
  output logic          byte_done,
  output logic          addr_phase,
  output logic [CW-1:0] byte_cnt,
  output logic          overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [BW-1:0] ACK_IDX  = BW'(DATA_BITS);
  localparam logic [BW-1:0] LAST_IDX = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BYTES);

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] bit_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          ovf_nxt;
  logic          done_nxt;
  logic          addr_cnt;
  logic          addr_cnt_nxt;

  always_ff @(posedge scl or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_idx   <= '0;
      byte_cnt  <= '0;
      overflow  <= 1'b0;
      byte_done <= 1'b0;
      addr_cnt  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_idx   <= bit_nxt;
      byte_cnt  <= cnt_nxt;
      overflow  <= ovf_nxt;
      byte_done <= done_nxt;
      addr_cnt  <= addr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_nxt      = bit_idx;
    cnt_nxt      = byte_cnt;
    ovf_nxt      = overflow;
    done_nxt     = 1'b0;
    addr_cnt_nxt = addr_cnt;

    if (start) begin
      // The start edge itself samples bit 0 of the first address byte.
      state_nxt    = ADDR;
      bit_nxt      = '0;
      cnt_nxt      = '0;
      ovf_nxt      = 1'b0;
      addr_cnt_nxt = 1'b0;
    end else if (stop) begin
      // Overflow is deliberately left alone so software can see it after the frame.
      state_nxt    = IDLE;
      bit_nxt      = '0;
      cnt_nxt      = '0;
      addr_cnt_nxt = 1'b0;
    end else if (state != IDLE) begin
      if (bit_idx == ACK_IDX) begin
        bit_nxt = '0;
        if (state == ADDR) begin
          if (ADDR10 == 0 || addr_cnt) begin
            state_nxt = DATA;
          end else begin
            addr_cnt_nxt = 1'b1;
          end
        end else if (byte_cnt == CNT_MAX) begin
          ovf_nxt = 1'b1;
        end else begin
          cnt_nxt = byte_cnt + CW'(1);
        end
      end else begin
        bit_nxt = bit_idx + BW'(1);
      end
      done_nxt = (bit_nxt == LAST_IDX);
    end
  end

  assign busy       = (state != IDLE);
  assign addr_phase = (state == ADDR);
  assign ack_slot   = busy && (bit_idx == ACK_IDX);

endmodule

// File: tb/tb_i2c_frame_counter.sv
// Bench for i2c_frame_counter: three parameterisations share one stimulus
// stream and are compared against a position-based frame model.
module tb_i2c_frame_counter;

  logic scl;
  logic rst_n;
  logic start;
  logic stop;

  logic       busy0, ack0, done0, ap0, ovf0;
  logic [3:0] bit0;
  logic [4:0] cnt0;
  logic       busy1, ack1, done1, ap1, ovf1;
  logic [3:0] bit1;
  logic [4:0] cnt1;
  logic       busy2, ack2, done2, ap2, ovf2;
  logic [3:0] bit2;
  logic [1:0] cnt2;

  i2c_frame_counter u0 (
    .scl(scl), .rst_n(rst_n), .start(start), .stop(stop),
    .busy(busy0), .bit_idx(bit0), .ack_slot(ack0), .byte_done(done0),
    .addr_phase(ap0), .byte_cnt(cnt0), .overflow(ovf0)
  );

  i2c_frame_counter #(.ADDR10(1)) u1 (
    .scl(scl), .rst_n(rst_n), .start(start), .stop(stop),
    .busy(busy1), .bit_idx(bit1), .ack_slot(ack1), .byte_done(done1),
    .addr_phase(ap1), .byte_cnt(cnt1), .overflow(ovf1)
  );

  i2c_frame_counter #(.MAX_BYTES(2)) u2 (
    .scl(scl), .rst_n(rst_n), .start(start), .stop(stop),
    .busy(busy2), .bit_idx(bit2), .ack_slot(ack2), .byte_done(done2),
    .addr_phase(ap2), .byte_cnt(cnt2), .overflow(ovf2)
  );

  initial scl = 1'b0;
  always #5 scl = ~scl;

  // Model: each instance only needs "edges since start", busy and a sticky overflow.
  int db[3]  = '{8, 8, 8};
  int mb[3]  = '{16, 16, 2};
  int a10[3] = '{0, 1, 0};
  bit m_busy[3];
  int m_pos[3];
  bit m_ovf[3];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 1'b0;
      m_pos[i]  = 0;
      m_ovf[i]  = 1'b0;
    end
  endtask

  task automatic model_edge(bit s, bit p);
    int k, comp;
    for (int i = 0; i < 3; i++) begin
      if (s) begin
        m_busy[i] = 1'b1;
        m_pos[i]  = 0;
        m_ovf[i]  = 1'b0;
      end else if (p) begin
        m_busy[i] = 1'b0;
        m_pos[i]  = 0;
      end else if (m_busy[i]) begin
        m_pos[i]++;
      end
      if (m_busy[i]) begin
        k    = m_pos[i] / (db[i] + 1);
        comp = k - (a10[i] != 0 ? 2 : 1);
        m_ovf[i] = (comp > mb[i]);
      end
    end
  endtask

  task automatic check_inst(int i, logic b, logic [15:0] bi, logic ack,
                            logic dn, logic ap, logic [15:0] cnt, logic ov);
    int e_bi, k, comp, e_cnt;
    bit e_ap, e_dn, e_ack;
    e_bi  = m_busy[i] ? m_pos[i] % (db[i] + 1) : 0;
    k     = m_pos[i] / (db[i] + 1);
    comp  = k - (a10[i] != 0 ? 2 : 1);
    if (comp < 0 || !m_busy[i]) comp = 0;
    e_cnt = (comp > mb[i]) ? mb[i] : comp;
    e_ap  = m_busy[i] && (k < (a10[i] != 0 ? 2 : 1));
    e_dn  = m_busy[i] && (e_bi == db[i] - 1);
    e_ack = m_busy[i] && (e_bi == db[i]);
    chk($sformatf("u%0d.busy", i), 16'(b), 16'(m_busy[i]));
    chk($sformatf("u%0d.bit_idx", i), bi, 16'(e_bi));
    chk($sformatf("u%0d.ack_slot", i), 16'(ack), 16'(e_ack));
    chk($sformatf("u%0d.byte_done", i), 16'(dn), 16'(e_dn));
    chk($sformatf("u%0d.addr_phase", i), 16'(ap), 16'(e_ap));
    chk($sformatf("u%0d.byte_cnt", i), cnt, 16'(e_cnt));
    chk($sformatf("u%0d.overflow", i), 16'(ov), 16'(m_ovf[i]));
  endtask

  task automatic check_all();
    check_inst(0, busy0, 16'(bit0), ack0, done0, ap0, 16'(cnt0), ovf0);
    check_inst(1, busy1, 16'(bit1), ack1, done1, ap1, 16'(cnt1), ovf1);
    check_inst(2, busy2, 16'(bit2), ack2, done2, ap2, 16'(cnt2), ovf2);
  endtask

  task automatic step(bit s, bit p);
    @(negedge scl);
    start = s;
    stop  = p;
    @(posedge scl);
    model_edge(s, p);
    #1;
    check_all();
  endtask

  task automatic run_idle(int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0);
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge scl);
    rst_n = 1'b1;

    // Edges without a start do nothing; a stray stop in IDLE is ignored.
    run_idle(3);
    step(1'b0, 1'b1);

    // Long frame: covers 7-bit and 10-bit address phases and first data bytes.
    step(1'b1, 1'b0);
    run_idle(30);
    step(1'b0, 1'b1);
    run_idle(2);

    // Enough data bytes to saturate the MAX_BYTES=2 instance; overflow survives stop.
    step(1'b1, 1'b0);
    run_idle(40);
    step(1'b0, 1'b1);
    run_idle(3);
    step(1'b1, 1'b0);

    // Repeated start at bit 5 of the first data byte.
    run_idle(13);
    step(1'b1, 1'b0);
    run_idle(4);

    // Start and stop together: start wins, then a lone stop ends the frame.
    step(1'b1, 1'b1);
    run_idle(3);
    step(1'b0, 1'b1);

    // Asynchronous reset between edges at bit 4.
    step(1'b1, 1'b0);
    run_idle(4);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge scl);
    rst_n = 1'b1;
    run_idle(5);

    // Random traffic with occasional start/stop/both.
    for (int j = 0; j < 600; j++) begin
      r = $urandom_range(0, 99);
      step(r < 3 || r == 99, (r >= 3 && r < 6) || r == 99);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
